// File: rtl/deserializer_pkg.sv
// deserializer_pkg: frame FSM state encoding and default widths shared by the serial link blocks.
package deserializer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 5;
endpackage

// File: rtl/deser_shift_reg.sv
// deser_shift_reg: LSB-first shift register with bit counter, clear and terminal-count flag.
module deser_shift_reg #(
  parameter int W = 16,
  parameter int CW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          shift_en,
  input  logic          clr,
  input  logic          din,
  output logic [W-1:0]  q_next,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  logic [W-1:0] q;
  assign q_next = {din, q[W-1:1]};
  assign tc = cnt == CW'(W - 1);
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      q <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      q <= q_next;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/deserializer.sv
// deserializer: collects DATA_WIDTH serial bits LSB first into P_DATA with valid pulse and overrun flag.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  deser_en,
  input  logic                  bit_strobe,
  input  logic                  S_DATA,
  input  logic                  data_ack,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  deser_busy,
  output logic [CNT_WIDTH-1:0]  bit_cnt,
  output logic                  overrun
);
  state_t state, state_next;
  logic [DATA_WIDTH-1:0] shifted;
  logic shift_en, clr, tc, complete, pending;
  assign shift_en = deser_en && bit_strobe && state != DONE;
  assign clr = state == DONE || (state == SHIFT && !deser_en);
  assign complete = state == SHIFT && shift_en && tc;
  deser_shift_reg #(.W(DATA_WIDTH), .CW(CNT_WIDTH)) u_sr (
    .CLK(CLK), .RST(RST), .shift_en(shift_en), .clr(clr), .din(S_DATA),
    .q_next(shifted), .cnt(bit_cnt), .tc(tc)
  );
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state == IDLE  ? (deser_en ? SHIFT : IDLE) :
                 state == SHIFT ? (!deser_en ? IDLE : complete ? DONE : SHIFT) :
                                  (deser_en ? SHIFT : IDLE);
  end
  always_comb begin
    DATA_VALID = state == DONE;
    deser_busy = state == SHIFT;
  end
  // P_DATA loads on the capturing edge so it is already valid during the DONE pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (complete) P_DATA <= shifted;
      if (state == DONE) begin
        pending <= 1'b1;
        if (pending && !data_ack) overrun <= 1'b1;
      end else if (data_ack) pending <= 1'b0;
    end
  end
endmodule
